// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selector values and legal
// oversampling ratios. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three mid-bit samples and a 2-of-3 vote.
// Produces a strobe once the vote is settled and another on the last tick of a bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  mid_done_o,
  output logic                  bit_done_o,
  output logic                  bit_val_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] edge_cnt_d;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic [2:0]            samp;

  assign half = prescale_i >> 1;
  assign last = prescale_i - ONE;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (clear_i) begin
      edge_cnt_d = '0;
    end else if (en_i) begin
      edge_cnt_d = (edge_cnt_q == last) ? '0 : edge_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Taps sit at half-1, half and half+1 around the bit centre.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    localparam logic [PRESCALE_W-1:0] OFS = PRESCALE_W'(gi);
    logic [PRESCALE_W-1:0] tap;
    logic                  samp_q;

    assign tap = half - ONE + OFS;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        samp_q <= 1'b1;
      end else if (en_i && !clear_i && (edge_cnt_q == tap)) begin
        samp_q <= rx_i;
      end
    end

    assign samp[gi] = samp_q;
  end

  assign bit_val_o  = majority3(samp[0], samp[1], samp[2]);
  assign mid_done_o = en_i && (edge_cnt_q == (half + ONE + ONE));
  assign bit_done_o = en_i && (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / data (LSB first) / optional parity / stop framing with
// single-cycle result pulses. Back-to-back frames are accepted without an idle bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_mis_q, par_mis_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic smp_clear;
  logic smp_en;
  logic mid_done;
  logic bit_done;
  logic bit_val;
  logic start_frame;
  logic exp_par;

  assign smp_en  = (state_q != ST_IDLE);
  assign exp_par = (par_typ_q == PARITY_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (smp_clear),
    .en_i       (smp_en),
    .rx_i       (RX_IN),
    .prescale_i (prescale_q),
    .mid_done_o (mid_done),
    .bit_done_o (bit_done),
    .bit_val_o  (bit_val)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_mis_d    = par_mis_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    prescale_d   = prescale_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    smp_clear    = 1'b0;
    start_frame  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        // A start bit that votes high was only a glitch.
        if (mid_done && bit_val) begin
          state_d = ST_IDLE;
        end else if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d[bit_cnt_q] = bit_val;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          par_mis_d = (bit_val != exp_par);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          par_err_d = par_mis_q;
          stp_err_d = !bit_val;
          if (!par_mis_q && bit_val) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
          // Line already low here means the next start bit follows immediately.
          if (!RX_IN) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      state_d    = ST_START;
      bit_cnt_d  = '0;
      par_mis_d  = 1'b0;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      prescale_d = Prescale;
      smp_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_mis_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      prescale_q   <= PRESCALE_W'(PRESCALE_16);
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_mis_q    <= par_mis_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      prescale_q   <= prescale_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver consuming the TX_OUT line of the UART transmitter (loopback or external link).
- Recovers start / 8 data / optional parity / stop frames using an oversampled clock.
- Presents P_DATA with a one-cycle data_valid pulse to the register/system controller.
- Runs in the UART clock domain. Frame format mirrors the transmitter: LSB first, idle high, PAR_TYP 0 = even, 1 = odd.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_W, 6, width of the Prescale input.

Ports:
clk  input  1  UART oversampling clock; all logic rising-edge.
rst  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high; externally synchronised to clk.
PAR_EN  input  1  1 = frame contains a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  PRESCALE_W  clk cycles per bit; legal values 8, 16, 32.
P_DATA  output  DATA_WIDTH  last correctly received byte.
data_valid  output  1  one-cycle pulse: P_DATA updated with an error-free frame.
par_err  output  1  one-cycle pulse: parity mismatch in the frame just ended.
stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - Counters clear.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - Reset mid-frame abandons the frame with no pulse.
- Config latch: PAR_EN, PAR_TYP and Prescale are captured when leaving IDLE. Changes mid-frame take effect on the next frame.
- Counters:
  - edge_cnt runs 0..P-1 within each bit (P = latched Prescale), then wraps to 0.
  - bit_cnt advances on each wrap.
- Sampling:
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, valid from the cycle edge_cnt = P/2+2.
- States:
  - IDLE: RX_IN=0 -> START, with edge_cnt=0 on the following cycle.
  - START: after sampling, if the majority is 1 (glitch) -> IDLE, no pulses. Else at edge_cnt=P-1 -> DATA.
  - DATA: majority shifts into shift register bit position bit_cnt (LSB first). After bit 7 wraps: PAR_EN ? PARITY : STOP.
  - PARITY: expected parity is ^data for even, ~^data for odd. The result is held as a mismatch flag. At edge_cnt=P-1 -> STOP.
  - STOP: majority 0 sets the stop-error flag. At edge_cnt=P-1 the outputs below are registered, then the next state is taken.
- End-of-frame outputs (registered, pulses on the cycle after STOP's edge_cnt=P-1, exactly one cycle high):
  - No errors: P_DATA <= shift register, data_valid=1.
  - Parity mismatch: par_err=1, data_valid=0.
  - Stop low: stp_err=1, data_valid=0.
  - Both errors: par_err and stp_err assert together.
  - On any error P_DATA holds its previous value.
- Next state after STOP:
  - RX_IN=0 at that cycle -> START directly (back-to-back frames, no idle bit required).
  - Otherwise -> IDLE.
- Latency: data_valid rises (1+8+PAR_EN+1)*P + 1 cycles after the cycle in which IDLE sees RX_IN=0. P=16 without parity gives 161.
- Prescale outside {8,16,32}: behaviour unspecified, no hang guaranteed only for values >= 4.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP, 3-bit, shared with the TX FSM encoding width;
  - PARITY_EVEN=0, PARITY_ODD=1;
  - legal prescale constants 8/16/32.
- Sub-module uart_rx_sampler: edge_cnt, the three-sample capture, majority vote and bit_done strobe.
- FSM, shift register, parity/stop check and output registers stay in uart_rx.

Test Plan:
- P=16, PAR_EN=0, send 0xA5 -> data_valid single pulse, P_DATA=0xA5, par_err=stp_err=0, pulse 161 cycles after start edge.
- P=8, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C valid. Same byte with parity bit 1 -> par_err pulse, P_DATA keeps old value, data_valid=0.
- P=32, PAR_TYP=1, send 0x00 with stop bit 0 -> stp_err pulse only. Repeat with a bad parity bit as well -> par_err and stp_err in the same cycle.
- RX_IN low for 3 cycles then high at P=16 -> back to IDLE, no pulses. Following 0x5A frame -> received correctly.
- Back-to-back 0x01, 0xFF, 0x80 with no idle gap at P=16 -> three data_valid pulses, exactly 10*P cycles apart.
- Assert rst during DATA bit 4 of 0x77, release, send 0x12 -> no pulse for the aborted frame, outputs 0 during reset, then P_DATA=0x12 valid.
